rv32i_clint_bridge: RTL and testbench

- Memory-mapped core-local interrupt (CLINT) bridge on the core's data-memory port, alongside the data RAM.
- Decodes core stores to the CLINT window and assembles 64-bit mtime/mtimecmp values from 32-bit halves.
- Drives the core's timer-write inputs (mtime_wr, mtimecmp_wr, mtime_din, mtimecmp_din), software_interrupt and synchronised external_interrupt.
- Returns registered read data with the same 1-cycle latency as the data RAM.

---
 rtl/rv32i_clint_bridge.sv | 152 +++++++++++++++
 tb/tb_rv32i_clint_bridge.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/rv32i_clint_bridge.sv
// CLINT bridge on the core data port: msip, mtime/mtimecmp staging and commit pulses, ext IRQ sync.
// Optional CLINT_RESET_CMP_EN: a one-cycle INIT state after reset pulses mtimecmp_wr with all-ones.
module rv32i_clint_bridge #(
  parameter logic [31:0] CLINT_BASE = 32'h0200_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] daddr,
  input  logic [31:0] dout,
  input  logic [3:0]  wr_mask,
  input  logic        wr_en,
  output logic        periph_sel,
  output logic [31:0] periph_rdata,
  output logic        mtime_wr,
  output logic        mtimecmp_wr,
  output logic [63:0] mtime_din,
  output logic [63:0] mtimecmp_din,
  output logic        software_interrupt,
  input  logic        ext_irq_async,
  output logic        external_interrupt
);

  localparam logic [15:0] OFF_MSIP   = 16'h0000;
  localparam logic [15:0] OFF_CMP_LO = 16'h4000;
  localparam logic [15:0] OFF_CMP_HI = 16'h4004;
  localparam logic [15:0] OFF_TIM_LO = 16'hBFF8;
  localparam logic [15:0] OFF_TIM_HI = 16'hBFFC;

  function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                             input logic [31:0] wdat,
                                             input logic [3:0]  mask);
    logic [31:0] res;
    for (int b = 0; b < 4; b++)
      res[8*b +: 8] = mask[b] ? wdat[8*b +: 8] : cur[8*b +: 8];
    return res;
  endfunction

  logic [31:0] tim_stg_q, tim_stg_d, cmp_stg_q, cmp_stg_d;
  logic [63:0] tim_din_q, tim_din_d, cmp_din_q, cmp_din_d;
  logic        tim_wr_q, tim_wr_d, cmp_wr_q, cmp_wr_d;
  logic        msip_q, msip_d;
  logic        sel_q, sel_d;
  logic [31:0] rdata_q, rdata_d;
  logic        sync1_q, sync2_q;
  logic        hit, wr_hit, cmp_hi_we;
  logic [15:0] off;

  assign off       = daddr[15:0];
  assign hit       = (daddr[31:16] == CLINT_BASE[31:16]) && (daddr[1:0] == 2'b00);
  assign wr_hit    = hit && wr_en && (wr_mask != 4'b0000);
  assign cmp_hi_we = wr_hit && (off == OFF_CMP_HI);

  always_comb begin
    tim_stg_d = tim_stg_q;
    cmp_stg_d = cmp_stg_q;
    tim_din_d = tim_din_q;
    cmp_din_d = cmp_din_q;
    tim_wr_d  = 1'b0;
    cmp_wr_d  = 1'b0;
    msip_d    = msip_q;
    sel_d     = 1'b0;
    rdata_d   = rdata_q;
    if (wr_hit) begin
      case (off)
        OFF_MSIP:   if (wr_mask[0]) msip_d = dout[0];
        OFF_CMP_LO: cmp_stg_d = byte_merge(cmp_stg_q, dout, wr_mask);
        OFF_CMP_HI: begin
          cmp_din_d = {byte_merge(cmp_din_q[63:32], dout, wr_mask), cmp_stg_q};
          cmp_wr_d  = 1'b1;
        end
        OFF_TIM_LO: tim_stg_d = byte_merge(tim_stg_q, dout, wr_mask);
        OFF_TIM_HI: begin
          tim_din_d = {byte_merge(tim_din_q[63:32], dout, wr_mask), tim_stg_q};
          tim_wr_d  = 1'b1;
        end
        default: ;
      endcase
    end
    if (hit && !wr_en) begin
      sel_d = 1'b1;
      case (off)
        OFF_MSIP:   rdata_d = {31'b0, msip_q};
        OFF_CMP_LO: rdata_d = cmp_stg_q;
        OFF_CMP_HI: rdata_d = cmp_din_q[63:32];
        OFF_TIM_LO: rdata_d = tim_stg_q;
        OFF_TIM_HI: rdata_d = tim_din_q[63:32];
        default:    rdata_d = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tim_stg_q <= 32'h0;
      cmp_stg_q <= 32'hFFFF_FFFF;
      tim_din_q <= 64'h0;
      cmp_din_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      tim_wr_q  <= 1'b0;
      cmp_wr_q  <= 1'b0;
      msip_q    <= 1'b0;
      sel_q     <= 1'b0;
      rdata_q   <= 32'h0;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
    end else begin
      tim_stg_q <= tim_stg_d;
      cmp_stg_q <= cmp_stg_d;
      tim_din_q <= tim_din_d;
      cmp_din_q <= cmp_din_d;
      tim_wr_q  <= tim_wr_d;
      cmp_wr_q  <= cmp_wr_d;
      msip_q    <= msip_d;
      sel_q     <= sel_d;
      rdata_q   <= rdata_d;
      sync1_q   <= ext_irq_async;
      sync2_q   <= sync1_q;
    end
  end

`ifdef CLINT_RESET_CMP_EN
  typedef enum logic {ST_INIT, ST_IDLE} state_t;
  state_t state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_INIT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: state_d = ST_IDLE;
      default: state_d = state_q;
    endcase
  end

  // cmp_din_q still holds its all-ones reset value during INIT; a HI commit in
  // INIT pulses next cycle instead, so the INIT pulse is dropped to keep one pulse.
  assign mtimecmp_wr = cmp_wr_q | ((state_q == ST_INIT) && !cmp_hi_we);
`else
  assign mtimecmp_wr = cmp_wr_q;
`endif

  assign mtime_wr           = tim_wr_q;
  assign mtime_din          = tim_din_q;
  assign mtimecmp_din       = cmp_din_q;
  assign software_interrupt = msip_q;
  assign periph_sel         = sel_q;
  assign periph_rdata       = rdata_q;
  assign external_interrupt = sync2_q;

endmodule

// File: tb/tb_rv32i_clint_bridge.sv
// Directed bench for rv32i_clint_bridge (default build): stores, reads, commits, sync and reset.
module tb_rv32i_clint_bridge;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] daddr, dout;
  logic [3:0]  wr_mask;
  logic        wr_en;
  logic        periph_sel;
  logic [31:0] periph_rdata;
  logic        mtime_wr, mtimecmp_wr;
  logic [63:0] mtime_din, mtimecmp_din;
  logic        software_interrupt;
  logic        ext_irq_async;
  logic        external_interrupt;

  int n_cmp = 0;
  int n_err = 0;

  rv32i_clint_bridge #(.CLINT_BASE(32'h0200_0000)) dut (
    .clk(clk), .rst(rst), .daddr(daddr), .dout(dout), .wr_mask(wr_mask), .wr_en(wr_en),
    .periph_sel(periph_sel), .periph_rdata(periph_rdata),
    .mtime_wr(mtime_wr), .mtimecmp_wr(mtimecmp_wr),
    .mtime_din(mtime_din), .mtimecmp_din(mtimecmp_din),
    .software_interrupt(software_interrupt),
    .ext_irq_async(ext_irq_async), .external_interrupt(external_interrupt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a store for one cycle; returns on the following negedge.
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    @(negedge clk);
    daddr = a; dout = d; wr_mask = m; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; daddr = 32'h0; wr_mask = 4'h0;
  endtask

  task automatic read(input logic [31:0] a);
    @(negedge clk);
    daddr = a; wr_en = 1'b0;
    @(negedge clk);
    daddr = 32'h0;
  endtask

  initial begin
    rst = 1'b1; daddr = 32'h0; dout = 32'h0; wr_mask = 4'h0; wr_en = 1'b0; ext_irq_async = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mtime_wr", mtime_wr, 0);
    chk("rst_cmp_wr", mtimecmp_wr, 0);
    chk("rst_mtime_din", mtime_din, 64'h0);
    chk("rst_cmp_din", mtimecmp_din, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst_sel", periph_sel, 0);
    chk("rst_rdata", periph_rdata, 0);
    chk("rst_swi", software_interrupt, 0);
    chk("rst_ext", external_interrupt, 0);

    // mtimecmp LO then HI
    store(32'h0200_4000, 32'h0000_1000, 4'hF);
    chk("cmp_lo_nopulse", mtimecmp_wr, 0);
    chk("cmp_lo_din_hold", mtimecmp_din, 64'hFFFF_FFFF_FFFF_FFFF);
    store(32'h0200_4004, 32'h0000_0002, 4'hF);
    chk("cmp_hi_pulse", mtimecmp_wr, 1);
    chk("cmp_hi_din", mtimecmp_din, 64'h0000_0002_0000_1000);
    @(negedge clk);
    chk("cmp_hi_pulse_end", mtimecmp_wr, 0);
    read(32'h0200_4000);
    chk("rd_cmp_lo_sel", periph_sel, 1);
    chk("rd_cmp_lo", periph_rdata, 32'h0000_1000);
    read(32'h0200_4004);
    chk("rd_cmp_hi", periph_rdata, 32'h0000_0002);

    // mtime HI partial mask, no prior LO
    store(32'h0200_BFFC, 32'hAABB_CCDD, 4'b0011);
    chk("tim_hi_pulse", mtime_wr, 1);
    chk("tim_hi_cmp_quiet", mtimecmp_wr, 0);
    chk("tim_hi_din", mtime_din, 64'h0000_CCDD_0000_0000);
    @(negedge clk);
    chk("tim_hi_pulse_end", mtime_wr, 0);

    // back-to-back HI commits reuse held LO
    @(negedge clk);
    daddr = 32'h0200_4004; dout = 32'h5; wr_mask = 4'hF; wr_en = 1'b1;
    @(negedge clk);
    dout = 32'h6;
    chk("b2b_pulse1", mtimecmp_wr, 1);
    chk("b2b_din1", mtimecmp_din, 64'h0000_0005_0000_1000);
    @(negedge clk);
    wr_en = 1'b0; daddr = 32'h0; wr_mask = 4'h0;
    chk("b2b_pulse2", mtimecmp_wr, 1);
    chk("b2b_din2", mtimecmp_din, 64'h0000_0006_0000_1000);
    @(negedge clk);
    chk("b2b_end", mtimecmp_wr, 0);

    // msip
    store(32'h0200_0000, 32'h1, 4'h1);
    chk("swi_set", software_interrupt, 1);
    read(32'h0200_0000);
    chk("rd_msip_sel", periph_sel, 1);
    chk("rd_msip", periph_rdata, 32'h1);
    @(negedge clk);
    chk("idle_sel", periph_sel, 0);
    chk("idle_rdata_hold", periph_rdata, 32'h1);
    store(32'h0200_0000, 32'h0, 4'h1);
    chk("swi_clr", software_interrupt, 0);

    // misaligned and out-of-window, plus zero-mask HI
    store(32'h0200_4002, 32'hDEAD_BEEF, 4'hF);
    chk("mis_nopulse", mtimecmp_wr, 0);
    store(32'h0300_4004, 32'hDEAD_BEEF, 4'hF);
    chk("oow_nopulse", mtimecmp_wr, 0);
    store(32'h0200_4004, 32'hDEAD_BEEF, 4'h0);
    chk("mask0_nopulse", mtimecmp_wr, 0);
    chk("bad_wr_din", mtimecmp_din, 64'h0000_0006_0000_1000);
    read(32'h0200_4002);
    chk("mis_rd_sel", periph_sel, 0);
    read(32'h0300_4000);
    chk("oow_rd_sel", periph_sel, 0);
    read(32'h0200_4000);
    chk("stg_untouched", periph_rdata, 32'h0000_1000);
    read(32'h0200_0100);
    chk("unmapped_sel", periph_sel, 1);
    chk("unmapped_rd", periph_rdata, 32'h0);

    // external interrupt synchroniser
    @(negedge clk);
    ext_irq_async = 1'b1;
    @(negedge clk);
    chk("ext_1cyc", external_interrupt, 0);
    @(negedge clk);
    chk("ext_2cyc", external_interrupt, 1);
    ext_irq_async = 1'b0;

    // reset asserted together with a HI write
    store(32'h0200_BFF8, 32'h0000_1234, 4'hF);
    @(negedge clk);
    daddr = 32'h0200_BFFC; dout = 32'h7; wr_mask = 4'hF; wr_en = 1'b1; rst = 1'b1;
    #1;
    chk("rst_hi_nopulse_now", mtime_wr, 0);
    @(negedge clk);
    wr_en = 1'b0; daddr = 32'h0; wr_mask = 4'h0;
    chk("rst_hi_nopulse", mtime_wr, 0);
    chk("rst_hi_din", mtime_din, 64'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_hi_nopulse_after", mtime_wr, 0);
    read(32'h0200_BFF8);
    chk("rst_tim_stg", periph_rdata, 32'h0);
    read(32'h0200_4000);
    chk("rst_cmp_stg", periph_rdata, 32'hFFFF_FFFF);
    chk("rst_cmp_din2", mtimecmp_din, 64'hFFFF_FFFF_FFFF_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
